// File: rtl/uart_rx_dma_ctrl.sv
// UART RX to blockram DMA channel; CPU has priority on the RAM write port.
// Optional circular mode is compiled in with `define DMA_CIRC_EN.
module uart_rx_dma_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        cpu_req,
  output logic        ram_we,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ie_q, ie_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [31:0]        run_base_q, run_base_d;
  logic [LEN_W-1:0]   run_len_q, run_len_d;
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]         fifo_q [FIFO_DEPTH];
  logic               circ;

`ifdef DMA_CIRC_EN
  logic circ_q, circ_d;
  assign circ = circ_q;
`else
  assign circ = 1'b0;
`endif

  logic             ctrl_wr, start_req, abort_req;
  logic             fifo_empty, fifo_full;
  logic             issue, push, drop;
  logic [7:0]       head;
  logic [31:0]      wr_addr;
  logic [LEN_W-1:0] count_inc;

  assign ctrl_wr    = cfg_we && (cfg_addr == 2'd0);
  assign start_req  = ctrl_wr && cfg_wdata[0] && (state_q != RUN);
  assign abort_req  = ctrl_wr && cfg_wdata[2] && (state_q == RUN);

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign issue      = (state_q == RUN) && !fifo_empty && !cpu_req && !abort_req;
  // A full FIFO still accepts a byte when the head drains in the same cycle.
  assign push       = (state_q == RUN) && rx_valid && !abort_req && (!fifo_full || issue);
  assign drop       = (state_q == RUN) && rx_valid && !abort_req && fifo_full && !issue;

  assign head       = fifo_q[rptr_q[AW-1:0]];
  assign wr_addr    = run_base_q + 32'(count_q);
  assign count_inc  = count_q + LEN_W'(1);

  assign ram_we     = issue;
  assign ram_be     = issue ? (4'b0001 << wr_addr[1:0]) : '0;
  assign ram_addr   = issue ? wr_addr : '0;
  assign ram_wdata  = issue ? {4{head}} : '0;
  assign busy       = (state_q == RUN);
  assign irq        = done_q & ie_q;

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0:    cfg_rdata = {28'd0, ie_q, 1'b0, circ, 1'b0};
      2'd1:    cfg_rdata = base_q;
      2'd2:    cfg_rdata = 32'(len_q);
      default: cfg_rdata = {16'(count_q), 13'd0, ovf_q, done_q, busy};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    ie_d       = ie_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    run_base_d = run_base_q;
    run_len_d  = run_len_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
`ifdef DMA_CIRC_EN
    circ_d     = circ_q;
`endif

    if (cfg_we) begin
      unique case (cfg_addr)
        2'd0: begin
          ie_d = cfg_wdata[3];
`ifdef DMA_CIRC_EN
          circ_d = cfg_wdata[1];
`endif
        end
        2'd1: base_d = cfg_wdata;
        2'd2: len_d  = cfg_wdata[LEN_W-1:0];
        default: begin
          if (cfg_wdata[1]) done_d = 1'b0;
          if (cfg_wdata[2]) ovf_d  = 1'b0;
        end
      endcase
    end

    if (push) wptr_d = wptr_q + (AW+1)'(1);
    if (issue) rptr_d = rptr_q + (AW+1)'(1);
    if (drop) ovf_d = 1'b1;

    unique case (state_q)
      RUN: begin
        if (abort_req) begin
          state_d = IDLE;
          wptr_d  = '0;
          rptr_d  = '0;
        end else if (issue) begin
          count_d = count_inc;
          if (count_inc == run_len_q) begin
            done_d = 1'b1;
            if (circ) count_d = '0;
            else      state_d = DONE;
          end
        end
      end
      default: begin
        if (start_req) begin
          run_base_d = base_q;
          run_len_d  = len_q;
          count_d    = '0;
          wptr_d     = '0;
          rptr_d     = '0;
          if (len_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            done_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      ie_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      run_base_q <= '0;
      run_len_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
`ifdef DMA_CIRC_EN
      circ_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      ie_q       <= ie_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      run_base_q <= run_base_d;
      run_len_q  <= run_len_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
`ifdef DMA_CIRC_EN
      circ_q     <= circ_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_dma_ctrl.sv
// Scoreboard bench for uart_rx_dma_ctrl: expected RAM writes are queued as
// bytes are driven and matched against ram_we beats on the falling edge.
module tb_uart_rx_dma_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        irq;

  uart_rx_dma_ctrl #(.FIFO_DEPTH(8), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .rx_valid(rx_valid), .rx_data(rx_data), .cpu_req(cpu_req),
    .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && ram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {28'd0, ram_addr[3:0]}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", ram_addr, e.addr);
        check("wr_be", {28'd0, ram_be}, {28'd0, e.be});
        check("wr_data", ram_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic expect_wr, input logic [31:0] addr);
    wr_t e;
    rx_valid = 1'b1; rx_data = b;
    if (expect_wr) begin
      e.addr = addr;
      e.be   = 4'b0001 << addr[1:0];
      e.data = {4{b}};
      exp_q.push_back(e);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    rx_valid = 1'b0; rx_data = '0; cpu_req = 1'b0;
    repeat (3) tick();
    check("rst_ram_we", {31'd0, ram_we}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), r);
      check("rst_reg", r, 0);
    end
    resetn = 1'b1;
    tick();

    // Basic 3-byte transfer with interrupt enabled
    cfg_write(2'd1, 32'h100);
    cfg_write(2'd2, 32'd3);
    cfg_write(2'd0, 32'h9);
    check("t1_busy", {31'd0, busy}, 1);
    push_byte(8'h41, 1'b1, 32'h100);
    push_byte(8'h42, 1'b1, 32'h101);
    push_byte(8'h43, 1'b1, 32'h102);
    wait_drain("t1_drain", 20);
    check("t1_busy_end", {31'd0, busy}, 0);
    read_reg(2'd3, r);
    check("t1_status", r, 32'h0003_0002);
    check("t1_irq_ie", {31'd0, irq}, 1);
    cfg_write(2'd0, 32'h0);
    check("t1_irq_noie", {31'd0, irq}, 0);

    // CPU holds the port for 5 cycles
    cfg_write(2'd1, 32'h200);
    cfg_write(2'd2, 32'd1);
    cfg_write(2'd0, 32'h1);
    cpu_req = 1'b1;
    push_byte(8'h55, 1'b1, 32'h200);
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_we", {31'd0, ram_we}, 0);
      tick();
    end
    cpu_req = 1'b0;
    #1;
    check("t2_first_free_we", {31'd0, ram_we}, 1);
    wait_drain("t2_drain", 10);
    read_reg(2'd3, r);
    check("t2_status", r, 32'h0001_0002);

    // Overflow: 9 bytes into an 8-entry FIFO
    cfg_write(2'd1, 32'h300);
    cfg_write(2'd2, 32'd16);
    cfg_write(2'd0, 32'h1);
    cpu_req = 1'b1;
    for (int i = 0; i < 9; i++)
      push_byte(8'(8'h60 + i), i < 8, 32'h300 + 32'(i));
    read_reg(2'd3, r);
    check("t3_ovf_set", r, 32'h0000_0005);
    cpu_req = 1'b0;
    wait_drain("t3_drain", 30);
    read_reg(2'd3, r);
    check("t3_status", r, 32'h0008_0005);
    cfg_write(2'd3, 32'h4);
    read_reg(2'd3, r);
    check("t3_ovf_clr", r, 32'h0008_0001);
    cfg_write(2'd0, 32'h4);
    check("t3_abort_busy", {31'd0, busy}, 0);

    // Zero-length transfer
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd0, 32'h1);
    check("t4_busy", {31'd0, busy}, 0);
    read_reg(2'd3, r);
    check("t4_status", r, 32'h0000_0002);
    repeat (3) tick();

    // Abort with one byte still queued
    cfg_write(2'd1, 32'h400);
    cfg_write(2'd2, 32'd4);
    cfg_write(2'd0, 32'h1);
    push_byte(8'h71, 1'b1, 32'h400);
    push_byte(8'h72, 1'b1, 32'h401);
    wait_drain("t5_drain", 10);
    cpu_req = 1'b1;
    push_byte(8'h73, 1'b0, 32'h0);
    cfg_write(2'd0, 32'h4);
    check("t5_busy", {31'd0, busy}, 0);
    read_reg(2'd3, r);
    check("t5_done_busy", {30'd0, r[1:0]}, 0);
    cpu_req = 1'b0;
    repeat (6) tick();

    // Reset in the middle of a transfer
    cfg_write(2'd1, 32'h500);
    cfg_write(2'd0, 32'h9);
    cpu_req = 1'b1;
    push_byte(8'h81, 1'b0, 32'h0);
    push_byte(8'h82, 1'b0, 32'h0);
    resetn = 1'b0;
    tick();
    cpu_req = 1'b0;
    #1;
    check("t6_ram_we", {31'd0, ram_we}, 0);
    check("t6_ram_be", {28'd0, ram_be}, 0);
    check("t6_ram_addr", ram_addr, 0);
    check("t6_ram_wdata", ram_wdata, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_irq", {31'd0, irq}, 0);
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), r);
      check("t6_reg", r, 0);
    end
    resetn = 1'b1;
    tick();

    cfg_write(2'd0, 32'h2);
    read_reg(2'd0, r);
`ifdef DMA_CIRC_EN
    check("t7_circ_rd", r, 32'h2);
    cfg_write(2'd1, 32'h600);
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd0, 32'h3);
    push_byte(8'h91, 1'b1, 32'h600);
    push_byte(8'h92, 1'b1, 32'h601);
    push_byte(8'h93, 1'b1, 32'h600);
    push_byte(8'h94, 1'b1, 32'h601);
    wait_drain("t7_drain", 20);
    check("t7_busy", {31'd0, busy}, 1);
    read_reg(2'd3, r);
    check("t7_status", r, 32'h0000_0003);
    cfg_write(2'd0, 32'h4);
`else
    check("t7_circ_rd", r, 32'h0);
    cfg_write(2'd1, 32'h600);
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd0, 32'h3);
    push_byte(8'h91, 1'b1, 32'h600);
    push_byte(8'h92, 1'b1, 32'h601);
    wait_drain("t7_drain", 20);
    check("t7_busy", {31'd0, busy}, 0);
    read_reg(2'd3, r);
    check("t7_status", r, 32'h0002_0002);
`endif
    repeat (3) tick();
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
